result_select_unit: RTL and testbench
=====================================

Name: result_select_unit

Overview:
- Parametrised, registered successor to the combinational function-code result mux of the integer datapath.
- Accepts one operation per handshake and owns the Hi/Lo registers.
- Sequences a multicycle unsigned divider and returns a single registered result word with valid and write-enable qualifiers to writeback.
- Adds MTHI/MTLO, illegal-code flagging and divider timeout, none of which the combinational mux had.

Parameters:
WIDTH, 32, datapath width of all data ports and Hi/Lo registers
MAX_DIV_CYCLES, 64, cycles waited for div_done before timeout (>=1)

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  synchronous, active-high reset
op_valid  input  1  operation request
op_ready  output  1  unit can accept; high only in IDLE
funct  input  6  function code, sampled at accept
alu_in  input  WIDTH  ALU result, sampled at accept
shift_in  input  WIDTH  shifter result, sampled at accept
src_a  input  WIDTH  rs operand for MTHI/MTLO, sampled at accept
div_start  output  1  one-cycle divider start pulse
div_done  input  1  divider completion strobe
div_quot  input  WIDTH  quotient, valid with div_done
div_rem  input  WIDTH  remainder, valid with div_done
res_valid  output  1  one-cycle result strobe
res_data  output  WIDTH  result word, valid with res_valid
res_wen  output  1  GPR write required, valid with res_valid
hi_out  output  WIDTH  current Hi register
lo_out  output  WIDTH  current Lo register
err_illegal  output  1  pulse with res_valid: unknown funct
err_timeout  output  1  pulse with res_valid: divider timeout

Behaviour:
- Reset: state=IDLE, hi=lo=0, res_data=0, res_valid=res_wen=div_start=err_illegal=err_timeout=0, counter=0. Reset in any state, including WAIT_DIV, aborts the operation and emits no result.
- Accept = op_valid && op_ready.
- States:
  - IDLE: op_ready=1.
  - WAIT_DIV: op_ready=0.
- Funct codes:
  - funct[5]=1: ALU class, any low bits (AND 100100, OR 100101, ADD 100000, SUB 100010, SLT 101010, ...).
  - SLL=000000, DIVU=011011, MFHI=010000, MTHI=010001, MFLO=010010, MTLO=010011.
- Single-cycle ops, accepted in IDLE, result in the next cycle (latency 1):
  - ALU class: res_data=alu_in, res_wen=1.
  - SLL: res_data=shift_in, res_wen=1.
  - MFHI/MFLO: res_data=hi/lo as held at the accept edge, res_wen=1.
  - MTHI/MTLO: hi/lo<=src_a at the accept edge; res_data=src_a, res_wen=0.
  - Any other code: res_data=0, res_wen=0, err_illegal=1.
- DIVU:
  - Accept in IDLE: go to WAIT_DIV, counter<=0. div_start=1 in the first WAIT_DIV cycle only.
  - In WAIT_DIV, div_done is sampled every cycle, including the div_start cycle. The counter increments each cycle without done.
  - div_done=1: hi<=div_rem, lo<=div_quot. The next cycle gives res_valid=1, res_data=div_rem (new Hi), res_wen=0, state=IDLE.
  - Counter reaches MAX_DIV_CYCLES without done: hi/lo unchanged. The next cycle gives res_valid=1, res_data=0, res_wen=0, err_timeout=1, state=IDLE.
  - Total latency from accept = (cycles to done)+1.
- res_valid/res_wen/err_* are one-cycle pulses; res_data holds its last value between pulses.
- Back-to-back: a new op may be accepted in the same cycle as the previous result's res_valid (IDLE). MFHI accepted the cycle after an MTHI accept returns the new value, because Hi/Lo are updated at the accept edge.
- div_done outside WAIT_DIV is ignored, with no state change.
- div_done coincident with the timeout cycle: done wins.
- hi_out/lo_out are direct register outputs and update on the edge of the write.

Test Plan:
- After reset, accept ADD with alu_in=0x0000_0007 → next cycle res_valid=1, res_data=7, res_wen=1; hi_out=lo_out=0.
- Back-to-back MTHI src_a=0xDEAD_BEEF, then MFHI → cycle 1 res_wen=0, res_data=0xDEADBEEF; cycle 2 res_data=0xDEADBEEF, res_wen=1.
- DIVU, divider asserts div_done 5 cycles after div_start with quot=3, rem=1 → op_ready=0 throughout; then lo_out=3, hi_out=1; res_valid with res_data=1, res_wen=0; op_ready=1.
- DIVU with div_done never asserted, MAX_DIV_CYCLES=4 → res_valid with err_timeout=1, res_data=0; hi/lo unchanged.
- funct=6'b000111 → res_valid=1, err_illegal=1, res_wen=0, res_data=0. Stray div_done in IDLE → no outputs change.
- Reset asserted 2 cycles into WAIT_DIV, then div_done → no res_valid; hi=lo=0; op_ready=1 after reset is released.

Source files
------------

// File: rtl/result_select_unit_if.sv
//-----------------------------------------------------------------------------
// result_select_unit_if: operation, divider and writeback signals of the
// result select unit. Rev 1.0
//-----------------------------------------------------------------------------
`default_nettype none

interface result_select_unit_if #(
   parameter int WIDTH = 32
);
   logic             op_valid;
   logic             op_ready;
   logic [5:0]       funct;
   logic [WIDTH-1:0] alu_in;
   logic [WIDTH-1:0] shift_in;
   logic [WIDTH-1:0] src_a;
   logic             div_start;
   logic             div_done;
   logic [WIDTH-1:0] div_quot;
   logic [WIDTH-1:0] div_rem;
   logic             res_valid;
   logic [WIDTH-1:0] res_data;
   logic             res_wen;
   logic [WIDTH-1:0] hi_out;
   logic [WIDTH-1:0] lo_out;
   logic             err_illegal;
   logic             err_timeout;

   modport master (
      output op_valid, funct, alu_in, shift_in, src_a,
      output div_done, div_quot, div_rem,
      input  op_ready, div_start,
      input  res_valid, res_data, res_wen, hi_out, lo_out,
      input  err_illegal, err_timeout
   );

   modport slave (
      input  op_valid, funct, alu_in, shift_in, src_a,
      input  div_done, div_quot, div_rem,
      output op_ready, div_start,
      output res_valid, res_data, res_wen, hi_out, lo_out,
      output err_illegal, err_timeout
   );
endinterface

`default_nettype wire

// File: rtl/result_select_unit.sv
//-----------------------------------------------------------------------------
// result_select_unit: registered result mux owning Hi/Lo and sequencing a
// multicycle divider with timeout. Rev 1.0
//-----------------------------------------------------------------------------
`default_nettype none

module result_select_unit #(
   parameter int WIDTH          = 32,
   parameter int MAX_DIV_CYCLES = 64
) (
   input  logic                 clk,
   input  logic                 reset,
   result_select_unit_if.slave  bus
);
   localparam int CNT_W = $clog2(MAX_DIV_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_DIV_CYCLES - 1);

   localparam logic [0:0] IDLE     = 1'b0;
   localparam logic [0:0] WAIT_DIV = 1'b1;

   localparam logic [5:0] F_SLL  = 6'b000000;
   localparam logic [5:0] F_MFHI = 6'b010000;
   localparam logic [5:0] F_MTHI = 6'b010001;
   localparam logic [5:0] F_MFLO = 6'b010010;
   localparam logic [5:0] F_MTLO = 6'b010011;
   localparam logic [5:0] F_DIVU = 6'b011011;

   logic [0:0]       state;
   logic [CNT_W-1:0] count;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic [WIDTH-1:0] res_data;
   logic             res_valid;
   logic             res_wen;
   logic             err_illegal;
   logic             err_timeout;
   logic             div_start;
   logic             accept;

   assign accept = bus.op_valid && (state == IDLE);

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         count       <= '0;
         hi          <= '0;
         lo          <= '0;
         res_data    <= '0;
         res_valid   <= 1'b0;
         res_wen     <= 1'b0;
         err_illegal <= 1'b0;
         err_timeout <= 1'b0;
         div_start   <= 1'b0;
      end else begin
         res_valid   <= 1'b0;
         res_wen     <= 1'b0;
         err_illegal <= 1'b0;
         err_timeout <= 1'b0;
         div_start   <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  if (bus.funct[5]) begin
                     res_valid <= 1'b1;
                     res_data  <= bus.alu_in;
                     res_wen   <= 1'b1;
                  end else begin
                     case (bus.funct)
                        F_SLL: begin
                           res_valid <= 1'b1;
                           res_data  <= bus.shift_in;
                           res_wen   <= 1'b1;
                        end
                        F_MFHI: begin
                           res_valid <= 1'b1;
                           res_data  <= hi;
                           res_wen   <= 1'b1;
                        end
                        F_MFLO: begin
                           res_valid <= 1'b1;
                           res_data  <= lo;
                           res_wen   <= 1'b1;
                        end
                        F_MTHI: begin
                           hi        <= bus.src_a;
                           res_valid <= 1'b1;
                           res_data  <= bus.src_a;
                        end
                        F_MTLO: begin
                           lo        <= bus.src_a;
                           res_valid <= 1'b1;
                           res_data  <= bus.src_a;
                        end
                        F_DIVU: begin
                           state     <= WAIT_DIV;
                           count     <= '0;
                           div_start <= 1'b1;
                        end
                        default: begin
                           res_valid   <= 1'b1;
                           res_data    <= '0;
                           err_illegal <= 1'b1;
                        end
                     endcase
                  end
               end
            end
            WAIT_DIV: begin
               // Completion is checked before the timeout so a late done still wins.
               if (bus.div_done) begin
                  hi        <= bus.div_rem;
                  lo        <= bus.div_quot;
                  res_valid <= 1'b1;
                  res_data  <= bus.div_rem;
                  state     <= IDLE;
               end else if (count == CNT_LAST) begin
                  res_valid   <= 1'b1;
                  res_data    <= '0;
                  err_timeout <= 1'b1;
                  state       <= IDLE;
               end else begin
                  count <= count + CNT_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.op_ready    = (state == IDLE);
   assign bus.div_start   = div_start;
   assign bus.res_valid   = res_valid;
   assign bus.res_data    = res_data;
   assign bus.res_wen     = res_wen;
   assign bus.hi_out      = hi;
   assign bus.lo_out      = lo;
   assign bus.err_illegal = err_illegal;
   assign bus.err_timeout = err_timeout;

endmodule

`default_nettype wire

// File: tb/tb_result_select_unit.sv
//-----------------------------------------------------------------------------
// tb_result_select_unit: randomized scoreboard bench for result_select_unit.
// Rev 1.0
//-----------------------------------------------------------------------------
`default_nettype none

module tb_result_select_unit;
   localparam int W    = 32;
   localparam int MAXC = 6;
   localparam logic [5:0] F_DIVU = 6'b011011;

   typedef struct {
      logic [W-1:0] data;
      logic         wen;
      logic         ill;
      logic         tmo;
      logic [W-1:0] hi;
      logic [W-1:0] lo;
   } exp_t;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   result_select_unit_if #(.WIDTH(W)) bus ();

   result_select_unit #(.WIDTH(W), .MAX_DIV_CYCLES(MAXC)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   exp_t         q[$];
   int           tests = 0;
   int           fails = 0;
   logic [W-1:0] m_hi  = '0;
   logic [W-1:0] m_lo  = '0;

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
      end
   endtask

   // Reference behaviour of the non-divide codes, expressed on the model Hi/Lo.
   function automatic exp_t model(input logic [5:0] f, input logic [W-1:0] a,
                                  input logic [W-1:0] s, input logic [W-1:0] src);
      exp_t e;
      e.data = '0; e.wen = 1'b0; e.ill = 1'b0; e.tmo = 1'b0;
      if (f[5]) begin
         e.data = a; e.wen = 1'b1;
      end else if (f == 6'd0) begin
         e.data = s; e.wen = 1'b1;
      end else if (f == 6'd16) begin
         e.data = m_hi; e.wen = 1'b1;
      end else if (f == 6'd18) begin
         e.data = m_lo; e.wen = 1'b1;
      end else if (f == 6'd17) begin
         m_hi = src; e.data = src;
      end else if (f == 6'd19) begin
         m_lo = src; e.data = src;
      end else begin
         e.ill = 1'b1;
      end
      e.hi = m_hi;
      e.lo = m_lo;
      return e;
   endfunction

   task automatic issue(input logic [5:0] f, input logic [W-1:0] a,
                        input logic [W-1:0] s, input logic [W-1:0] src);
      check("op_ready_idle", {31'b0, bus.op_ready}, 1);
      bus.op_valid = 1'b1;
      bus.funct    = f;
      bus.alu_in   = a;
      bus.shift_in = s;
      bus.src_a    = src;
      q.push_back(model(f, a, s, src));
      @(negedge clk);
      bus.op_valid = 1'b0;
   endtask

   // d = WAIT cycle index at which the divider reports done; d >= MAXC never completes.
   task automatic issue_div(input int d, input logic [W-1:0] qv, input logic [W-1:0] rv);
      exp_t e;
      int   k;
      check("op_ready_idle", {31'b0, bus.op_ready}, 1);
      bus.op_valid = 1'b1;
      bus.funct    = F_DIVU;
      bus.alu_in   = $urandom;
      bus.shift_in = $urandom;
      bus.src_a    = $urandom;
      e.wen = 1'b0; e.ill = 1'b0;
      if (d < MAXC) begin
         m_hi = rv; m_lo = qv;
         e.data = rv; e.tmo = 1'b0;
      end else begin
         e.data = '0; e.tmo = 1'b1;
      end
      e.hi = m_hi;
      e.lo = m_lo;
      q.push_back(e);
      @(negedge clk);
      bus.op_valid = 1'b0;
      check("div_start_first", {31'b0, bus.div_start}, 1);
      check("op_ready_busy", {31'b0, bus.op_ready}, 0);
      k = 0;
      while (!bus.op_ready && k < MAXC + 4) begin
         bus.div_done = (k == d);
         bus.div_quot = (k == d) ? qv : W'($urandom);
         bus.div_rem  = (k == d) ? rv : W'($urandom);
         @(negedge clk);
         k++;
         if (!bus.op_ready) check("div_start_once", {31'b0, bus.div_start}, 0);
      end
      bus.div_done = 1'b0;
      check("div_latency", k, (d < MAXC) ? d + 1 : MAXC);
   endtask

   initial begin : monitor
      logic [W-1:0] last_data;
      logic         rs;
      exp_t         e;
      last_data = '0;
      forever begin
         @(posedge clk);
         rs = reset;
         #1;
         if (rs) begin
            last_data = '0;
         end else if (bus.res_valid) begin
            if (q.size() == 0) begin
               check("unexpected_result", 1, 0);
            end else begin
               e = q.pop_front();
               check("res_data", bus.res_data, e.data);
               check("res_wen", {31'b0, bus.res_wen}, {31'b0, e.wen});
               check("err_illegal", {31'b0, bus.err_illegal}, {31'b0, e.ill});
               check("err_timeout", {31'b0, bus.err_timeout}, {31'b0, e.tmo});
               check("hi_out", bus.hi_out, e.hi);
               check("lo_out", bus.lo_out, e.lo);
            end
            last_data = bus.res_data;
         end else begin
            check("idle_strobes", {29'b0, bus.res_wen, bus.err_illegal, bus.err_timeout}, 0);
            check("res_data_hold", bus.res_data, last_data);
         end
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : driver
      int sel;
      logic [5:0] f;
      bus.op_valid = 1'b0; bus.funct = '0; bus.alu_in = '0; bus.shift_in = '0;
      bus.src_a = '0; bus.div_done = 1'b0; bus.div_quot = '0; bus.div_rem = '0;
      repeat (3) @(negedge clk);
      check("rst_op_ready", {31'b0, bus.op_ready}, 1);
      check("rst_res_valid", {31'b0, bus.res_valid}, 0);
      check("rst_res_data", bus.res_data, 0);
      check("rst_hi", bus.hi_out, 0);
      check("rst_lo", bus.lo_out, 0);
      check("rst_div_start", {31'b0, bus.div_start}, 0);
      reset = 1'b0;

      issue(6'b100000, 32'h0000_0007, $urandom, $urandom);
      @(negedge clk);
      issue(6'b010001, $urandom, $urandom, 32'hDEAD_BEEF);
      issue(6'b010000, $urandom, $urandom, $urandom);
      @(negedge clk);
      issue_div(MAXC - 1, 32'd3, 32'd1);
      check("divu_hi", bus.hi_out, 32'd1);
      check("divu_lo", bus.lo_out, 32'd3);
      issue_div(MAXC + 2, $urandom, $urandom);
      issue(6'b000111, $urandom, $urandom, $urandom);

      // Stray divider completion while idle.
      bus.div_done = 1'b1; bus.div_quot = $urandom; bus.div_rem = $urandom;
      @(negedge clk);
      bus.div_done = 1'b0;
      @(negedge clk);
      check("stray_hi", bus.hi_out, m_hi);
      check("stray_lo", bus.lo_out, m_lo);
      check("stray_ready", {31'b0, bus.op_ready}, 1);

      // Reset in the middle of a divide discards it.
      check("op_ready_idle", {31'b0, bus.op_ready}, 1);
      bus.op_valid = 1'b1; bus.funct = F_DIVU;
      @(negedge clk);
      bus.op_valid = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      bus.div_done = 1'b1; bus.div_quot = $urandom; bus.div_rem = $urandom;
      @(negedge clk);
      bus.div_done = 1'b0;
      m_hi = '0; m_lo = '0;
      check("abort_ready", {31'b0, bus.op_ready}, 1);
      check("abort_hi", bus.hi_out, 0);
      check("abort_lo", bus.lo_out, 0);

      for (int n = 0; n < 300; n++) begin
         sel = $urandom_range(0, 9);
         case (sel)
            0, 1, 2: f = {1'b1, 5'($urandom)};
            3:       f = 6'b000000;
            4:       f = 6'b010000;
            5:       f = 6'b010010;
            6:       f = 6'b010001;
            7:       f = 6'b010011;
            default: f = 6'($urandom);
         endcase
         if (sel == 8 || f == F_DIVU)
            issue_div($urandom_range(0, MAXC + 1), $urandom, $urandom);
         else
            issue(f, $urandom, $urandom, $urandom);
         for (int g = $urandom_range(0, 2); g > 0; g--) begin
            bus.div_done = ($urandom_range(0, 3) == 0);
            bus.div_quot = $urandom;
            bus.div_rem  = $urandom;
            @(negedge clk);
            bus.div_done = 1'b0;
         end
      end

      repeat (3) @(negedge clk);
      check("queue_drained", q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

`default_nettype wire
